// File: rtl/dmem_pkg.sv
// Shared types, legal byte-mask encodings and defaults for the data-memory controller.
package dmem_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1000_0000;
  localparam int unsigned DMEM_DATA_W    = 32;
  localparam int unsigned DMEM_LANES     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RMW  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte, halfword and word lane masks accepted by the controller
  localparam logic [3:0] BM_B0 = 4'b0001;
  localparam logic [3:0] BM_B1 = 4'b0010;
  localparam logic [3:0] BM_B2 = 4'b0100;
  localparam logic [3:0] BM_B3 = 4'b1000;
  localparam logic [3:0] BM_H0 = 4'b0011;
  localparam logic [3:0] BM_H1 = 4'b1100;
  localparam logic [3:0] BM_W  = 4'b1111;

  // True for naturally aligned byte/half/word lane patterns only
  function automatic logic is_legal_mask(input logic [3:0] m);
    case (m)
      BM_B0, BM_B1, BM_B2, BM_B3, BM_H0, BM_H1, BM_W: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the load/store unit and the data-memory controller.
interface dmem_if;

  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_wren;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_bmask;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  // Load/store unit side
  modport master (
    output i_req_valid, i_req_addr, i_req_wren, i_req_wdata, i_req_bmask,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  // Controller side
  modport slave (
    input  i_req_valid, i_req_addr, i_req_wren, i_req_wdata, i_req_bmask,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

endinterface

// File: rtl/dmem_sram.sv
// Single-port word SRAM: synchronous read-first, whole-word write, no reset.
module dmem_sram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read returns the pre-write contents when read and write share an edge
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[addr];
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: address/mask decode, byte-lane read-modify-write and response.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  dmem_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    bmask_q, bmask_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_load_q, rsp_load_d;

  logic [31:0]   offset_c;
  logic          in_range_c;
  logic          req_err_c;
  logic          accept_c;
  logic [AW-1:0] req_idx_c;
  logic [31:0]   merged_c;

  logic          sram_re_c;
  logic          sram_we_c;
  logic [AW-1:0] sram_addr_c;
  logic [31:0]   sram_wdata_c;
  logic [31:0]   sram_rdata;

  // Address window check, word index and mask legality for the presented request
  always_comb begin
    offset_c   = bus.i_req_addr - BASE_ADDR;
    in_range_c = (bus.i_req_addr >= BASE_ADDR) && (offset_c < MEM_BYTES);
    req_err_c  = !in_range_c || !is_legal_mask(bus.i_req_bmask);
    req_idx_c  = offset_c[AW+1:2];
    accept_c   = bus.i_req_valid && (state_q == IDLE);
  end

  // Merge captured store lanes over the old word read during the accept edge
  always_comb begin
    merged_c = sram_rdata;
    for (int unsigned b = 0; b < DMEM_LANES; b++) begin
      if (bmask_q[b]) merged_c[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Next state, captured request fields, SRAM strobes and response flags
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    bmask_d      = bmask_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_load_d   = 1'b0;
    sram_re_c    = 1'b0;
    sram_we_c    = 1'b0;
    sram_addr_c  = req_idx_c;
    sram_wdata_c = bus.i_req_wdata;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          if (req_err_c) begin
            rsp_err_d = 1'b1;
          end else if (!bus.i_req_wren) begin
            sram_re_c  = 1'b1;
            rsp_load_d = 1'b1;
          end else if (bus.i_req_bmask == BM_W) begin
            sram_we_c = 1'b1;
          end else begin
            // Partial store: fetch old word now, write merged word next cycle
            sram_re_c   = 1'b1;
            idx_d       = req_idx_c;
            wdata_d     = bus.i_req_wdata;
            bmask_d     = bus.i_req_bmask;
            rsp_valid_d = 1'b0;
            state_d     = RMW;
          end
        end
      end
      RMW: begin
        sram_addr_c  = idx_q;
        sram_wdata_c = merged_c;
        sram_we_c    = 1'b1;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      bmask_q     <= bmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
    end
  end

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (i_clk),
    .re    (sram_re_c),
    .we    (sram_we_c),
    .addr  (sram_addr_c),
    .wdata (sram_wdata_c),
    .rdata (sram_rdata)
  );

  // SRAM output register is only exposed during a load response
  assign bus.o_req_ready = (state_q == IDLE);
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_rdata = rsp_load_q ? sram_rdata : 32'h0;

endmodule
